// File: rtl/lsu_handshake.sv
// lsu_handshake: multi-cycle load/store unit for the RV32I core.
// Sits between execute (effective address, rs2 data) and writeback (load
// data), talking to data memory over a request/grant/response interface.
// Handles byte-lane alignment, write strobes, load extension, misalignment
// faults and a response timeout, and stalls the core while busy.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   valid_i           execute-stage instruction valid
//   memren_i          load instruction
//   memwren_i         store instruction (wins if both are set)
//   funct3_i          access size/sign (B, H, W, BU, HU)
//   addr_i            effective byte address
//   store_data_i      rs2 value
//   stall_o           core must hold PC/inputs this cycle
//   done_o            one-cycle access-complete pulse
//   load_data_o       extended load result, valid with done_o
//   misaligned_o      misalignment/unsupported-access fault, valid with done_o
//   err_o             response timeout, valid with done_o
//   mem_req_o         memory request
//   mem_we_o          request is a write
//   mem_addr_o        word-aligned address
//   mem_wdata_o       lane-shifted store data
//   mem_wstrb_o       byte strobes
//   mem_gnt_i         request accepted
//   mem_rvalid_i      read data valid
//   mem_rdata_i       read word
module lsu_handshake #(
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid_i,
  input  logic                memren_i,
  input  logic                memwren_i,
  input  logic [2:0]          funct3_i,
  input  logic [AWIDTH-1:0]   addr_i,
  input  logic [DWIDTH-1:0]   store_data_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [DWIDTH-1:0]   load_data_o,
  output logic                misaligned_o,
  output logic                err_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_wstrb_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned NB = DWIDTH / 8;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
  logic                we_q, we_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       wstrb_q, wstrb_d;
  logic                mis_q, mis_d;
  logic                err_q, err_d;
  logic [DWIDTH-1:0]   ldata_q, ldata_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                start;
  logic [1:0]          dec_off;
  logic                dec_mis;
  logic [NB-1:0]       dec_wstrb;
  logic [DWIDTH-1:0]   dec_wdata;
  logic [DWIDTH-1:0]   rshift;
  logic [DWIDTH-1:0]   ext_data;

  assign start   = valid_i && (memren_i || memwren_i);
  assign dec_off = addr_i[1:0];

  // Request decode from the execute-stage inputs. Loads allow BU/HU; stores
  // only have B/H/W, so funct3 with bit 2 set is an unsupported store.
  always_comb begin
    dec_mis   = 1'b0;
    dec_wstrb = '0;
    dec_wdata = '0;
    unique case (funct3_i)
      3'b000: begin
        dec_wstrb = NB'(4'b0001) << dec_off;
        dec_wdata = DWIDTH'(store_data_i[7:0]) << {dec_off, 3'b000};
      end
      3'b001: begin
        dec_mis   = dec_off[0];
        dec_wstrb = dec_off[1] ? NB'(4'b1100) : NB'(4'b0011);
        dec_wdata = DWIDTH'(store_data_i[15:0]) << {dec_off[1], 4'b0000};
      end
      3'b010: begin
        dec_mis   = (dec_off != 2'b00);
        dec_wstrb = '1;
        dec_wdata = store_data_i;
      end
      3'b100: dec_mis = memwren_i;
      3'b101: dec_mis = memwren_i || dec_off[0];
      default: dec_mis = 1'b1;
    endcase
  end

  // Load path: move the addressed lane down to bit 0, then extend.
  assign rshift = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ext_data = rshift;
    unique case (f3_q)
      3'b000:  ext_data = {{(DWIDTH-8){rshift[7]}}, rshift[7:0]};
      3'b001:  ext_data = {{(DWIDTH-16){rshift[15]}}, rshift[15:0]};
      3'b100:  ext_data = {{(DWIDTH-8){1'b0}}, rshift[7:0]};
      3'b101:  ext_data = {{(DWIDTH-16){1'b0}}, rshift[15:0]};
      default: ext_data = rshift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    mis_d   = mis_q;
    err_d   = err_q;
    ldata_d = ldata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          off_d   = dec_off;
          f3_d    = funct3_i;
          we_d    = memwren_i;
          addr_d  = {addr_i[AWIDTH-1:2], 2'b00};
          wdata_d = dec_wdata;
          wstrb_d = dec_mis ? '0 : dec_wstrb;
          mis_d   = dec_mis;
          err_d   = 1'b0;
          if (dec_mis) begin
            ldata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          cnt_d = '0;
          if (we_q) begin
            ldata_d = '0;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          ldata_d = ext_data;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          ldata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      ldata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_o      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                        ((state_q == S_IDLE) && start);
  assign done_o       = (state_q == S_RESP);
  assign misaligned_o = (state_q == S_RESP) && mis_q;
  assign err_o        = (state_q == S_RESP) && err_q;
  assign load_data_o  = ldata_q;
  assign mem_req_o    = (state_q == S_REQ);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_wstrb_o  = wstrb_q;

endmodule
